gaussian_window_blur: RTL and testbench

Streaming, parametrised Gaussian blur for the SIFT scale-space front end. It takes a raster pixel stream and buffers `KSIZE-1` image rows internally. It applies a separable binomial kernel (3×3 or 5×5), rounds and normalises, and emits the valid-region blurred image with ready/valid backpressure. It sits between the frame source and the octave/DoG stages, and replaces the fixed 3×3, externally windowed blur.

---
 rtl/gaussian_pkg.sv | 32 +++
 rtl/gaussian_line_buffer.sv | 25 ++
 rtl/gaussian_window_blur.sv | 252 +++++++++++++++++++++++++
 tb/tb_gaussian_window_blur.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_pkg.sv
// Shared types and elaboration-time helpers for the streaming Gaussian blur.
// Weights are binomial coefficients, so every sum width follows from KSIZE alone.
package gaussian_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_e;

  // C(ksize-1, idx); each step stays an exact integer
  function automatic int binomial_weight(input int ksize, input int idx);
    int w;
    w = 1;
    for (int i = 0; i < idx; i++) begin
      w = w * (ksize - 1 - i) / (i + 1);
    end
    return w;
  endfunction

  function automatic int norm_shift(input int ksize);
    return 2 * (ksize - 1);
  endfunction

  function automatic int vsum_width(input int width, input int ksize);
    return width + ksize - 1;
  endfunction

  function automatic int hsum_width(input int width, input int ksize);
    return width + 2 * (ksize - 1);
  endfunction

endpackage

// File: rtl/gaussian_line_buffer.sv
// One image row of storage: asynchronous read-first access, write on enable.
// Read data reflects the old contents at addr_in until the clock edge commits the write.
module gaussian_line_buffer #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             wr_en_in,
  input  logic [AW-1:0]    addr_in,
  input  logic [WIDTH-1:0] wr_data_in,
  output logic [WIDTH-1:0] rd_data_out
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_data_out = mem_q[addr_in];

  always_ff @(posedge clk_in) begin
    if (wr_en_in) begin
      mem_q[addr_in] <= wr_data_in;
    end
  end

endmodule

// File: rtl/gaussian_window_blur.sv
// Streaming separable binomial blur (3x3 or 5x5) with internal line buffers,
// frame tracking, round-half-up normalisation and ready/valid backpressure.
module gaussian_window_blur
  import gaussian_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int KSIZE = 3,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] pixel_in,
  input  logic             pixel_valid_in,
  input  logic             sof_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid_out,
  output logic             last_out,
  input  logic             ready_in,
  output logic             error_out,
  output logic             busy_out
);

  localparam int S  = norm_shift(KSIZE);
  localparam int VW = vsum_width(WIDTH, KSIZE);
  localparam int HW = hsum_width(WIDTH, KSIZE);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int NB = KSIZE - 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KSIZE - 1);

  if (KSIZE != 3 && KSIZE != 5) begin : g_bad_ksize
    $error("gaussian_window_blur: KSIZE must be 3 or 5");
  end

  typedef logic [WIDTH-1:0] pix_vec_t  [KSIZE];
  typedef logic [VW-1:0]    vsum_vec_t [KSIZE];

  function automatic logic [VW-1:0] vert_sum(input pix_vec_t c);
    logic [VW-1:0] acc;
    acc = '0;
    for (int i = 0; i < KSIZE; i++) begin
      acc = acc + VW'(binomial_weight(KSIZE, i)) * VW'(c[i]);
    end
    return acc;
  endfunction

  function automatic logic [HW-1:0] horiz_sum(input vsum_vec_t v);
    logic [HW-1:0] acc;
    acc = '0;
    for (int j = 0; j < KSIZE; j++) begin
      acc = acc + HW'(binomial_weight(KSIZE, j)) * HW'(v[j]);
    end
    return acc;
  endfunction

  // Cannot overflow: the largest H plus the half-LSB still fits in HW bits
  function automatic logic [WIDTH-1:0] round_norm(input logic [HW-1:0] h);
    logic [HW-1:0] t;
    t = h + HW'(1 << (S - 1));
    return WIDTH'(t >> S);
  endfunction

  logic             en;
  logic             accept;
  logic             beat_ok;
  logic             in_region;
  logic             is_last;
  logic [CW-1:0]    pos_col;
  logic [RW-1:0]    pos_row;
  pix_vec_t         col_vec;
  logic [WIDTH-1:0] lb_rd [NB];
  logic [WIDTH-1:0] lb_wd [NB];

  frame_state_e  state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          error_q, error_d;

  pix_vec_t      col_p0_q, col_p0_d;
  logic          vld_p0_q, vld_p0_d;
  logic          out_p0_q, out_p0_d;
  logic          last_p0_q, last_p0_d;
  vsum_vec_t     v_sr_q, v_sr_d;
  logic          vld_p1_q, vld_p1_d;
  logic          last_p1_q, last_p1_d;
  logic [HW-1:0] h_p2_q, h_p2_d;
  logic          vld_p2_q, vld_p2_d;
  logic          last_p2_q, last_p2_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic          dvld_q, dvld_d;
  logic          dlast_q, dlast_d;

  assign en        = !dvld_q || ready_in;
  assign ready_out = en && !rst_in;
  assign accept    = pixel_valid_in && ready_out;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    error_d = error_q;
    beat_ok = 1'b0;
    pos_col = col_q;
    pos_row = row_q;
    if (accept) begin
      if (sof_in) begin
        beat_ok = 1'b1;
        pos_col = '0;
        pos_row = '0;
        if (state_q == ACTIVE) error_d = 1'b1;
        state_d = ACTIVE;
        col_d   = CW'(1);
        row_d   = '0;
      end else if (state_q == IDLE) begin
        error_d = 1'b1;
      end else begin
        beat_ok = 1'b1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
    in_region = (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
    // A restarting SOF beat is (0,0), so it can never also be the last pixel
    is_last   = !sof_in && (row_q == ROW_LAST) && (col_q == COL_LAST);
  end

  for (genvar k = 0; k < NB; k++) begin : g_lb
    if (k == 0) begin : g_head
      assign lb_wd[k] = pixel_in;
    end else begin : g_chain
      assign lb_wd[k] = lb_rd[k-1];
    end
    gaussian_line_buffer #(
      .WIDTH(WIDTH),
      .DEPTH(IMG_W)
    ) u_lb (
      .clk_in     (clk_in),
      .wr_en_in   (beat_ok),
      .addr_in    (pos_col),
      .wr_data_in (lb_wd[k]),
      .rd_data_out(lb_rd[k])
    );
  end

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      col_vec[i] = lb_rd[NB-1-i];
    end
    col_vec[KSIZE-1] = pixel_in;
  end

  always_comb begin
    col_p0_d  = col_p0_q;
    vld_p0_d  = vld_p0_q;
    out_p0_d  = out_p0_q;
    last_p0_d = last_p0_q;
    v_sr_d    = v_sr_q;
    vld_p1_d  = vld_p1_q;
    last_p1_d = last_p1_q;
    h_p2_d    = h_p2_q;
    vld_p2_d  = vld_p2_q;
    last_p2_d = last_p2_q;
    dout_d    = dout_q;
    dvld_d    = dvld_q;
    dlast_d   = dlast_q;
    if (en) begin
      // p0: column register
      col_p0_d  = col_vec;
      vld_p0_d  = beat_ok;
      out_p0_d  = in_region;
      last_p0_d = is_last;
      // p1: vertical sum enters the horizontal window, only for real beats
      if (vld_p0_q) begin
        v_sr_d[0] = vert_sum(col_p0_q);
        for (int k = 1; k < KSIZE; k++) begin
          v_sr_d[k] = v_sr_q[k-1];
        end
      end
      vld_p1_d  = vld_p0_q && out_p0_q;
      last_p1_d = vld_p0_q && last_p0_q;
      // p2: horizontal sum
      h_p2_d    = horiz_sum(v_sr_q);
      vld_p2_d  = vld_p1_q;
      last_p2_d = vld_p1_q && last_p1_q;
      // output: round and normalise
      if (vld_p2_q) dout_d = round_norm(h_p2_q);
      dvld_d  = vld_p2_q;
      dlast_d = vld_p2_q && last_p2_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      error_q   <= 1'b0;
      vld_p0_q  <= 1'b0;
      out_p0_q  <= 1'b0;
      last_p0_q <= 1'b0;
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      dout_q    <= '0;
      dvld_q    <= 1'b0;
      dlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      error_q   <= error_d;
      vld_p0_q  <= vld_p0_d;
      out_p0_q  <= out_p0_d;
      last_p0_q <= last_p0_d;
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
      dout_q    <= dout_d;
      dvld_q    <= dvld_d;
      dlast_q   <= dlast_d;
    end
  end

  always_ff @(posedge clk_in) begin
    col_p0_q <= col_p0_d;
    v_sr_q   <= v_sr_d;
    h_p2_q   <= h_p2_d;
  end

  assign data_out       = dout_q;
  assign data_valid_out = dvld_q;
  assign last_out       = dlast_q;
  assign error_out      = error_q;
  assign busy_out       = (state_q == ACTIVE);

endmodule

// File: tb/tb_gaussian_window_blur.sv
// Bench for gaussian_window_blur: a 3x3 8x6 instance and a 5x5 9x9 instance
// share one input stream; outputs of the selected instance are checked.
module tb_gaussian_window_blur;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_in, pixel_valid_in, sof_in, ready_in;
  logic [7:0] pixel_in;
  logic       rdy3, dv3, last3, err3, busy3;
  logic [7:0] d3;
  logic       rdy5, dv5, last5, err5, busy5;
  logic [7:0] d5;
  logic       sel;

  logic       cur_rdy, cur_dv, cur_last, cur_err, cur_busy;
  logic [7:0] cur_d;
  assign cur_rdy  = sel ? rdy5  : rdy3;
  assign cur_dv   = sel ? dv5   : dv3;
  assign cur_last = sel ? last5 : last3;
  assign cur_err  = sel ? err5  : err3;
  assign cur_busy = sel ? busy5 : busy3;
  assign cur_d    = sel ? d5    : d3;

  gaussian_window_blur #(.WIDTH(8), .KSIZE(3), .IMG_W(8), .IMG_H(6)) u_dut3 (
    .clk_in(clk), .rst_in(rst_in), .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
    .sof_in(sof_in), .ready_out(rdy3), .data_out(d3), .data_valid_out(dv3),
    .last_out(last3), .ready_in(ready_in), .error_out(err3), .busy_out(busy3));

  gaussian_window_blur #(.WIDTH(8), .KSIZE(5), .IMG_W(9), .IMG_H(9)) u_dut5 (
    .clk_in(clk), .rst_in(rst_in), .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in),
    .sof_in(sof_in), .ready_out(rdy5), .data_out(d5), .data_valid_out(dv5),
    .last_out(last5), .ready_in(ready_in), .error_out(err5), .busy_out(busy5));

  int total, bad;
  int img [0:80];
  int od  [0:127];
  int ol  [0:127];
  int ocnt, first_cyc, acc22_cyc, rdy_bad, err_at_sof, err_next;

  typedef struct {
    int test;
    int idx;
    int exp;
  } vec_t;
  vec_t vecs [0:19];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Direct 2-D weighted window over the stored image
  function automatic int ref_px(input int k, input int w, input int rr, input int cc);
    int wt [5];
    int s, hh;
    if (k == 3) wt = '{1, 2, 1, 0, 0};
    else        wt = '{1, 4, 6, 4, 1};
    hh = (k - 1) / 2;
    s  = 0;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        s += wt[i] * wt[j] * img[(rr - hh + i) * w + (cc - hh + j)];
    return (s + (1 << (2 * k - 3))) >> (2 * k - 2);
  endfunction

  task automatic check_model(input string tag, input int k, input int w, input int h, input int base);
    int nw;
    nw = w - k + 1;
    for (int i = 0; i < nw * (h - k + 1); i++)
      check(tag, od[base + i], ref_px(k, w, i / nw + (k - 1) / 2, i % nw + (k - 1) / 2));
  endtask

  task automatic check_lasts(input string tag, input int n);
    int c;
    c = 0;
    for (int i = 0; i < 128; i++) c += ol[i];
    check({tag, " last count"}, c, 1);
    check({tag, " last position"}, ol[n-1], 1);
  endtask

  task automatic do_reset(input int sel_i);
    sel = sel_i[0];
    rst_in = 1'b1; pixel_valid_in = 1'b0; sof_in = 1'b0; ready_in = 1'b1; pixel_in = '0;
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
  endtask

  // mode: 0 ready_in high, 1 ten-cycle stall window, 2 random ready_in
  task automatic run_frame(input int sel_i, input int w, input int npix, input int sof_first,
                           input int sof_b, input int mode, input int rst_at);
    int idx, cyc, drain, pidx, sof_cyc;
    sel = sel_i[0];
    ocnt = 0; idx = 0; cyc = 0; drain = 0; sof_cyc = -1;
    first_cyc = -1; acc22_cyc = -1; rdy_bad = 0; err_at_sof = -1; err_next = -1;
    for (int i = 0; i < 128; i++) begin od[i] = -1; ol[i] = 0; end
    while (drain < 30) begin
      @(negedge clk);
      if (cyc >= 3000) begin
        check("frame timeout", cyc, 0);
        break;
      end
      if (idx < npix) begin
        pidx = (sof_b >= 0 && idx >= sof_b) ? idx - sof_b : idx;
        pixel_valid_in = 1'b1;
        pixel_in = 8'(img[pidx]);
        sof_in = (idx == 0 && sof_first != 0) || (idx == sof_b);
        case (mode)
          1:       ready_in = !(cyc >= 25 && cyc < 35);
          2:       ready_in = 1'($urandom_range(0, 1));
          default: ready_in = 1'b1;
        endcase
      end else begin
        pixel_valid_in = 1'b0; sof_in = 1'b0; ready_in = 1'b1;
        drain++;
      end
      if (idx == rst_at) begin
        rst_in = 1'b1;
        #1;
        check("ready_out during reset", int'(cur_rdy), 0);
        @(posedge clk);
        #1;
        rst_in = 1'b0; pixel_valid_in = 1'b0; sof_in = 1'b0;
        check("mid reset data_out", int'(cur_d), 0);
        check("mid reset data_valid_out", int'(cur_dv), 0);
        check("mid reset last_out", int'(cur_last), 0);
        check("mid reset error_out", int'(cur_err), 0);
        check("mid reset busy_out", int'(cur_busy), 0);
        break;
      end
      #1;
      if (sof_cyc >= 0 && cyc == sof_cyc + 1) err_next = int'(cur_err);
      if (cur_rdy != !(cur_dv && !ready_in)) rdy_bad++;
      if (cur_dv && ready_in) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (ocnt < 128) begin od[ocnt] = int'(cur_d); ol[ocnt] = int'(cur_last); end
        ocnt++;
      end
      if (pixel_valid_in && cur_rdy) begin
        if (idx == 2 * w + 2) acc22_cyc = cyc;
        if (idx == sof_b) begin err_at_sof = int'(cur_err); sof_cyc = cyc; end
        idx++;
      end
      cyc++;
    end
    pixel_valid_in = 1'b0; sof_in = 1'b0; ready_in = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0; sel = 1'b0;
    rst_in = 1'b1; pixel_valid_in = 1'b0; sof_in = 1'b0; ready_in = 1'b1; pixel_in = '0;

    vecs[0]  = '{0, 14, 64}; vecs[1]  = '{0, 13, 32}; vecs[2]  = '{0, 15, 32};
    vecs[3]  = '{0,  8, 32}; vecs[4]  = '{0, 20, 32}; vecs[5]  = '{0,  7, 16};
    vecs[6]  = '{0,  9, 16}; vecs[7]  = '{0, 19, 16}; vecs[8]  = '{0, 21, 16};
    vecs[9]  = '{0,  0,  0}; vecs[10] = '{0, 23,  0}; vecs[11] = '{0, 16,  0};
    vecs[12] = '{1,  6, 36}; vecs[13] = '{1,  7, 24}; vecs[14] = '{1,  5, 24};
    vecs[15] = '{1,  1, 24}; vecs[16] = '{1, 11, 24}; vecs[17] = '{1,  0, 16};
    vecs[18] = '{1,  8,  6}; vecs[19] = '{1, 24,  0};

    repeat (3) @(negedge clk);
    check("reset data_out", int'(cur_d), 0);
    check("reset data_valid_out", int'(cur_dv), 0);
    check("reset last_out", int'(cur_last), 0);
    check("reset error_out", int'(cur_err), 0);
    check("reset busy_out", int'(cur_busy), 0);
    rst_in = 1'b0;

    for (int i = 0; i < 81; i++) img[i] = 100;
    run_frame(0, 8, 48, 1, -1, 0, -1);
    check("const count", ocnt, 24);
    for (int i = 0; i < 24; i++) check("const value", od[i], 100);
    check_lasts("const", 24);
    check("const latency", first_cyc - acc22_cyc, 4);
    check("const busy after frame", int'(cur_busy), 0);
    check("const error", int'(cur_err), 0);

    for (int i = 0; i < 81; i++) img[i] = 0;
    img[3 * 8 + 3] = 255;
    run_frame(0, 8, 48, 1, -1, 0, -1);
    check("imp3 count", ocnt, 24);
    for (int v = 0; v < 20; v++)
      if (vecs[v].test == 0) check("imp3 pixel", od[vecs[v].idx], vecs[v].exp);

    do_reset(1);
    for (int i = 0; i < 81; i++) img[i] = 0;
    img[3 * 9 + 3] = 255;
    run_frame(1, 9, 81, 1, -1, 0, -1);
    check("imp5 count", ocnt, 25);
    for (int v = 0; v < 20; v++)
      if (vecs[v].test == 1) check("imp5 pixel", od[vecs[v].idx], vecs[v].exp);
    check_lasts("imp5", 25);

    do_reset(0);
    for (int i = 0; i < 81; i++) img[i] = (i * 5) & 255;
    for (int m = 0; m < 3; m++) begin
      run_frame(0, 8, 48, 1, -1, m, -1);
      check("ramp count", ocnt, 24);
      check_model("ramp pixel", 3, 8, 6, 0);
      check_lasts("ramp", 24);
      check("ramp ready_out rule violations", rdy_bad, 0);
    end

    do_reset(0);
    run_frame(0, 8, 68, 1, 20, 0, -1);
    check("restart count", ocnt, 26);
    check("restart partial 0", od[0], ref_px(3, 8, 1, 1));
    check("restart partial 1", od[1], ref_px(3, 8, 1, 2));
    check_model("restart pixel", 3, 8, 6, 2);
    check_lasts("restart", 26);
    check("error before sof beat", err_at_sof, 0);
    check("error cycle after sof beat", err_next, 1);
    check("error sticky", int'(cur_err), 1);

    do_reset(0);
    run_frame(0, 8, 10, 0, -1, 0, -1);
    check("nosof count", ocnt, 0);
    check("nosof error", int'(cur_err), 1);
    check("nosof busy", int'(cur_busy), 0);

    do_reset(0);
    for (int i = 0; i < 81; i++) img[i] = 100;
    run_frame(0, 8, 48, 1, -1, 0, 30);
    run_frame(0, 8, 48, 1, -1, 0, -1);
    check("post reset count", ocnt, 24);
    for (int i = 0; i < 24; i++) check("post reset value", od[i], 100);
    check_lasts("post reset", 24);
    check("post reset error", int'(cur_err), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
